// File: rtl/csr_trap_unit_if.sv
// Bus between the RV32I core datapath and csr_trap_unit.
// Carries the per-instruction trap sources from the decoder, LSU and PC unit,
// the CSR read/modify/write port, and the trap/mret redirect back to the PC unit.
//   master: core side (drives instruction info, samples csr_rdata/exception/mret/trap_vec)
//   slave : csr_trap_unit side
interface csr_trap_unit_if;
    logic        instr_valid;
    logic [31:0] pc_val;
    logic [31:0] instr_word;
    logic        illegal_instr;
    logic        ecall;
    logic        ebreak;
    logic        mret_req;
    logic        i_misaligned;
    logic        ld_misaligned;
    logic        st_misaligned;
    logic [31:0] mem_addr;
    logic        meip_async;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic        csr_no_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        exception;
    logic        mret;
    logic [31:0] trap_vec;

    modport master (
        output instr_valid, pc_val, instr_word, illegal_instr, ecall, ebreak, mret_req,
               i_misaligned, ld_misaligned, st_misaligned, mem_addr, meip_async,
               csr_en, csr_op, csr_no_write, csr_addr, csr_wdata,
        input  csr_rdata, exception, mret, trap_vec
    );

    modport slave (
        input  instr_valid, pc_val, instr_word, illegal_instr, ecall, ebreak, mret_req,
               i_misaligned, ld_misaligned, st_misaligned, mem_addr, meip_async,
               csr_en, csr_op, csr_no_write, csr_addr, csr_wdata,
        output csr_rdata, exception, mret, trap_vec
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle RV32I core.
// Ports:
//   CLK  - clock
//   RST  - synchronous, active-high reset
//   bus  - csr_trap_unit_if.slave: trap sources, CSR port, exception/mret/trap_vec
// Selects the highest-priority trap cause, updates mepc/mcause/mtval/mstatus,
// owns mcycle/minstret and the 2-flop external-interrupt synchroniser.
module csr_trap_unit #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input logic            CLK,
    input logic            RST,
    csr_trap_unit_if.slave bus
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;

    logic        meip_s1_q, meip_s2_q;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [XLEN-1:0] csr_old, csr_new;
    logic            csr_impl, csr_wr_req, csr_fault, csr_we;
    logic            irq_pending, any_cause, exc, mret_take;
    logic [31:0]     trap_cause, trap_tval, trap_base;

    // Combinational read of the pre-update value; also flags unimplemented addresses.
    always_comb begin
        csr_old  = '0;
        csr_impl = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:   csr_old = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0,
                                       mstatus_mie_q, 3'b0};
            ADDR_MISA:      csr_old = MISA_VAL;
            ADDR_MIE:       csr_old = {20'b0, mie_meie_q, 11'b0};
            ADDR_MTVEC:     csr_old = mtvec_q;
            ADDR_MSCRATCH:  csr_old = mscratch_q;
            ADDR_MEPC:      csr_old = mepc_q;
            ADDR_MCAUSE:    csr_old = mcause_q;
            ADDR_MTVAL:     csr_old = mtval_q;
            ADDR_MIP:       csr_old = {20'b0, meip_s2_q, 11'b0};
            ADDR_MCYCLE:    csr_old = mcycle_q[31:0];
            ADDR_MCYCLEH:   csr_old = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_old = minstret_q[31:0];
            ADDR_MINSTRETH: csr_old = minstret_q[63:32];
            ADDR_MHARTID:   csr_old = '0;
            default:        csr_impl = 1'b0;
        endcase
    end

    assign bus.csr_rdata = csr_old;

    // RW always writes; RS/RC write only when the source operand field is non-zero.
    assign csr_wr_req = bus.csr_en & ((bus.csr_op == 2'b01) |
                                      (bus.csr_op[1] & ~bus.csr_no_write));
    assign csr_fault  = bus.csr_en & (~csr_impl |
                                      ((bus.csr_addr[11:10] == 2'b11) & csr_wr_req));

    always_comb begin
        case (bus.csr_op)
            2'b01:   csr_new = bus.csr_wdata;
            2'b10:   csr_new = csr_old | bus.csr_wdata;
            2'b11:   csr_new = csr_old & ~bus.csr_wdata;
            default: csr_new = csr_old;
        endcase
    end

    assign irq_pending = meip_s2_q & mie_meie_q & mstatus_mie_q & bus.instr_valid;
    assign any_cause   = irq_pending | bus.illegal_instr | csr_fault | bus.ecall |
                         bus.ebreak | bus.i_misaligned | bus.ld_misaligned |
                         bus.st_misaligned;
    assign exc         = bus.instr_valid & any_cause & ~RST;
    assign mret_take   = bus.instr_valid & bus.mret_req & ~exc & ~RST;
    assign csr_we      = bus.instr_valid & csr_wr_req & ~exc;

    // Priority encoder: first matching cause wins.
    always_comb begin
        trap_cause = '0;
        trap_tval  = '0;
        if (irq_pending) begin
            trap_cause = CAUSE_IRQ;
        end else if (bus.illegal_instr | csr_fault) begin
            trap_cause = 32'd2;
            trap_tval  = bus.instr_word;
        end else if (bus.ecall) begin
            trap_cause = 32'd11;
        end else if (bus.ebreak) begin
            trap_cause = 32'd3;
            trap_tval  = bus.pc_val;
        end else if (bus.i_misaligned) begin
            trap_cause = 32'd0;
        end else if (bus.ld_misaligned) begin
            trap_cause = 32'd4;
            trap_tval  = bus.mem_addr;
        end else if (bus.st_misaligned) begin
            trap_cause = 32'd6;
            trap_tval  = bus.mem_addr;
        end
    end

    assign trap_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        if (mret_take) begin
            bus.trap_vec = mepc_q;
        end else if (exc & mtvec_q[0] & irq_pending) begin
            bus.trap_vec = trap_base + 32'd44;
        end else begin
            bus.trap_vec = trap_base;
        end
    end

    assign bus.exception = exc;
    assign bus.mret      = mret_take;

    // Next-state: counters tick, a CSR write may override, then trap/mret side effects.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, bus.instr_valid & ~exc};

        if (csr_we) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_new[3];
                    mstatus_mpie_d = csr_new[7];
                end
                ADDR_MIE:       mie_meie_d = csr_new[11];
                ADDR_MTVEC:     mtvec_d    = {csr_new[31:2], 1'b0, csr_new[0]};
                ADDR_MSCRATCH:  mscratch_d = csr_new;
                ADDR_MEPC:      mepc_d     = {csr_new[31:2], 2'b00};
                ADDR_MCAUSE:    mcause_d   = csr_new;
                ADDR_MTVAL:     mtval_d    = csr_new;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_new};
                ADDR_MCYCLEH:   mcycle_d   = {csr_new, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
                ADDR_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (exc) begin
            // Interrupt saves pc-4 so that the PC unit's mepc+4 resume re-executes it.
            mepc_d         = irq_pending ? {bus.pc_val[31:2] - 30'd1, 2'b00}
                                         : {bus.pc_val[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            meip_s1_q      <= 1'b0;
            meip_s2_q      <= 1'b0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            meip_s1_q      <= bus.meip_async;
            meip_s2_q      <= meip_s1_q;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a field/mask-level model.
module tb_csr_trap_unit;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    csr_trap_unit_if bus ();

    csr_trap_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;
    logic        m_s1, m_s2;
    bit          m_ok = 0;

    // values computed for the current input set
    logic        e_exc, e_mret, e_irq, e_we;
    logic [31:0] e_vec, e_rdata, e_cause, e_tval, e_new;

    function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
        m_read = 1;
        v      = 32'h0;
        case (a)
            12'h300: v = m_mstatus | 32'h1800;
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_s2 ? 32'h800 : 32'h0;
            12'hB00: v = m_mcycle[31:0];
            12'hB80: v = m_mcycle[63:32];
            12'hB02: v = m_minstret[31:0];
            12'hB82: v = m_minstret[63:32];
            12'hF14: v = 32'h0;
            default: m_read = 0;
        endcase
    endfunction

    // which bits of a (non-counter) CSR software can change
    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: wmask = 32'h0000_0088;
            12'h304: wmask = 32'h0000_0800;
            12'h305: wmask = 32'hFFFF_FFFD;
            12'h341: wmask = 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'h343: wmask = 32'hFFFF_FFFF;
            default: wmask = 32'h0;
        endcase
    endfunction

    function automatic void m_eval();
        logic [31:0] old, base;
        bit          impl, wr, fault;
        logic        c [7];
        logic [31:0] codes [7];
        logic [31:0] tv [7];
        impl    = m_read(bus.csr_addr, old);
        e_rdata = old;
        wr      = bus.csr_en && (bus.csr_op == 2'd1 || (bus.csr_op >= 2'd2 && !bus.csr_no_write));
        fault   = bus.csr_en && (!impl || (bus.csr_addr[11:10] == 2'b11 && wr));
        e_irq   = m_s2 && m_mie[11] && m_mstatus[3] && bus.instr_valid;
        c[0] = e_irq;                          codes[0] = 32'h8000_000B; tv[0] = 0;
        c[1] = bus.illegal_instr || fault;     codes[1] = 2;  tv[1] = bus.instr_word;
        c[2] = bus.ecall;                      codes[2] = 11; tv[2] = 0;
        c[3] = bus.ebreak;                     codes[3] = 3;  tv[3] = bus.pc_val;
        c[4] = bus.i_misaligned;               codes[4] = 0;  tv[4] = 0;
        c[5] = bus.ld_misaligned;              codes[5] = 4;  tv[5] = bus.mem_addr;
        c[6] = bus.st_misaligned;              codes[6] = 6;  tv[6] = bus.mem_addr;
        e_exc = 0; e_cause = 0; e_tval = 0;
        for (int i = 0; i < 7; i++) begin
            if (c[i] && !e_exc) begin
                e_exc = 1; e_cause = codes[i]; e_tval = tv[i];
            end
        end
        e_exc  = e_exc && bus.instr_valid && !RST;
        e_mret = bus.instr_valid && bus.mret_req && !e_exc && !RST;
        case (bus.csr_op)
            2'd1:    e_new = bus.csr_wdata;
            2'd2:    e_new = old | bus.csr_wdata;
            2'd3:    e_new = old & ~bus.csr_wdata;
            default: e_new = old;
        endcase
        e_we  = bus.instr_valid && wr && !e_exc;
        base  = m_mtvec & 32'hFFFF_FFFC;
        if (e_mret)                                  e_vec = m_mepc;
        else if (e_exc && m_mtvec[0] && e_irq)       e_vec = base + 32'd44;
        else                                         e_vec = base;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
            m_s1 = 0; m_s2 = 0; m_ok = 1;
        end else if (m_ok) begin
            logic [63:0] cyc, ins;
            logic [31:0] mk;
            m_eval();
            cyc = m_mcycle + 64'd1;
            ins = m_minstret + ((bus.instr_valid && !e_exc) ? 64'd1 : 64'd0);
            if (e_we) begin
                mk = wmask(bus.csr_addr);
                case (bus.csr_addr)
                    12'hB00: cyc = {m_mcycle[63:32], e_new};
                    12'hB80: cyc = {e_new, m_mcycle[31:0]};
                    12'hB02: ins = {m_minstret[63:32], e_new};
                    12'hB82: ins = {e_new, m_minstret[31:0]};
                    12'h300: m_mstatus  = (m_mstatus  & ~mk) | (e_new & mk);
                    12'h304: m_mie      = (m_mie      & ~mk) | (e_new & mk);
                    12'h305: m_mtvec    = (m_mtvec    & ~mk) | (e_new & mk);
                    12'h340: m_mscratch = e_new;
                    12'h341: m_mepc     = (m_mepc     & ~mk) | (e_new & mk);
                    12'h342: m_mcause   = e_new;
                    12'h343: m_mtval    = e_new;
                    default: ;
                endcase
            end
            if (e_exc) begin
                m_mepc    = (e_irq ? bus.pc_val - 32'd4 : bus.pc_val) & 32'hFFFF_FFFC;
                m_mcause  = e_cause;
                m_mtval   = e_tval;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (e_mret) begin
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end
            m_mcycle   = cyc;
            m_minstret = ins;
            m_s2 = m_s1;
            m_s1 = bus.meip_async;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // single compare process: every cycle once the model has seen reset
    always @(negedge CLK) begin
        #2;
        if (m_ok) begin
            m_eval();
            chk("exception", {31'b0, bus.exception}, {31'b0, e_exc});
            chk("mret", {31'b0, bus.mret}, {31'b0, e_mret});
            chk("trap_vec", bus.trap_vec, e_vec);
            chk("csr_rdata", bus.csr_rdata, e_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        bus.instr_valid = 0; bus.pc_val = 32'h1000; bus.instr_word = 32'h13;
        bus.illegal_instr = 0; bus.ecall = 0; bus.ebreak = 0; bus.mret_req = 0;
        bus.i_misaligned = 0; bus.ld_misaligned = 0; bus.st_misaligned = 0;
        bus.mem_addr = 0; bus.csr_en = 0; bus.csr_op = 0; bus.csr_no_write = 0;
        bus.csr_addr = 0; bus.csr_wdata = 0;
    endtask

    task automatic cyc();
        @(negedge CLK);
        clr();
        bus.instr_valid = 1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        cyc();
        bus.csr_en = 1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = wd;
        bus.csr_no_write = (op != 2'd1) && (wd == 0);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr(2'd2, a, 32'h0);
        #3 chk(nm, bus.csr_rdata, exp);
    endtask

    localparam logic [11:0] RAND_ADDR [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
        12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
        12'hB82, 12'hF14, 12'h7C0, 12'hC00};

    initial begin
        RST = 1;
        clr();
        bus.meip_async = 0;
        repeat (2) @(negedge CLK);
        // trap request during reset is ignored
        cyc(); bus.ecall = 1;
        #3 chk("reset_exc", {31'b0, bus.exception}, 32'h0);
        @(negedge CLK); RST = 0;

        rd_chk("mtvec_rst", 12'h305, 32'h0000_0100);
        rd_chk("misa", 12'h301, 32'h4000_0100);
        rd_chk("mstatus_rst", 12'h300, 32'h0000_1800);

        // ecall
        cyc(); bus.ecall = 1; bus.pc_val = 32'h200;
        #3 chk("ecall_exc", {31'b0, bus.exception}, 32'h1);
        chk("ecall_vec", bus.trap_vec, 32'h100);
        rd_chk("ecall_mepc", 12'h341, 32'h200);
        rd_chk("ecall_mcause", 12'h342, 32'd11);
        rd_chk("ecall_mstatus", 12'h300, 32'h1800);

        // vectored external interrupt
        csr(2'd1, 12'h305, 32'h101);
        csr(2'd2, 12'h300, 32'h8);
        csr(2'd1, 12'h304, 32'h800);
        cyc(); bus.meip_async = 1; bus.pc_val = 32'h2F4;
        #3 chk("irq_c0", {31'b0, bus.exception}, 32'h0);
        cyc(); bus.pc_val = 32'h2F8;
        #3 chk("irq_c1", {31'b0, bus.exception}, 32'h0);
        cyc(); bus.pc_val = 32'h300;
        #3 chk("irq_c2", {31'b0, bus.exception}, 32'h1);
        chk("irq_vec", bus.trap_vec, 32'h12C);
        cyc(); bus.meip_async = 0;
        rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
        rd_chk("irq_mepc", 12'h341, 32'h2FC);
        rd_chk("irq_mstatus", 12'h300, 32'h1880);

        // mret
        csr(2'd1, 12'h304, 32'h0);
        csr(2'd1, 12'h341, 32'h400);
        csr(2'd1, 12'h300, 32'h0);
        csr(2'd2, 12'h300, 32'h8);
        rd_chk("pre_mret", 12'h300, 32'h1808);
        cyc(); bus.mret_req = 1; bus.pc_val = 32'h500;
        #3 chk("mret", {31'b0, bus.mret}, 32'h1);
        chk("mret_vec", bus.trap_vec, 32'h400);
        rd_chk("post_mret", 12'h300, 32'h1880);

        // CSR access faults
        csr(2'd1, 12'h340, 32'hA5A5_0001);
        csr(2'd1, 12'hF14, 32'h5); bus.instr_word = 32'hF142_9073;
        #3 chk("ro_exc", {31'b0, bus.exception}, 32'h1);
        chk("ro_vec", bus.trap_vec, 32'h100);
        rd_chk("ro_mcause", 12'h342, 32'd2);
        rd_chk("ro_mtval", 12'h343, 32'hF142_9073);
        csr(2'd1, 12'h7C0, 32'h1234); bus.instr_word = 32'h7C01_10F3;
        #3 chk("unimp_exc", {31'b0, bus.exception}, 32'h1);
        rd_chk("unimp_mtval", 12'h343, 32'h7C01_10F3);
        rd_chk("unimp_mscratch", 12'h340, 32'hA5A5_0001);

        // mcycle carry into the high half
        csr(2'd1, 12'hB80, 32'h12);
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
        cyc();
        rd_chk("mcycle_wrap", 12'hB00, 32'h0);
        rd_chk("mcycleh_inc", 12'hB80, 32'h13);

        // trapping instruction leaves minstret alone; illegal beats ld_misaligned
        csr(2'd1, 12'hB02, 32'h50);
        cyc(); bus.illegal_instr = 1; bus.ld_misaligned = 1;
        bus.instr_word = 32'hDEAD_0003; bus.mem_addr = 32'h0000_0F01;
        rd_chk("minstret_hold", 12'hB02, 32'h50);
        rd_chk("prio_mcause", 12'h342, 32'd2);
        rd_chk("prio_mtval", 12'h343, 32'hDEAD_0003);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            clr();
            RST = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) bus.meip_async = ~bus.meip_async;
            bus.instr_valid   = ($urandom_range(0, 7) != 0);
            bus.pc_val        = $urandom;
            bus.instr_word    = $urandom;
            bus.mem_addr      = $urandom;
            bus.illegal_instr = ($urandom_range(0, 15) == 0);
            bus.ecall         = ($urandom_range(0, 15) == 0);
            bus.ebreak        = ($urandom_range(0, 15) == 0);
            bus.i_misaligned  = ($urandom_range(0, 15) == 0);
            bus.ld_misaligned = ($urandom_range(0, 15) == 0);
            bus.st_misaligned = ($urandom_range(0, 15) == 0);
            bus.csr_en        = ($urandom_range(0, 1) == 1);
            bus.csr_op        = 2'($urandom_range(1, 3));
            bus.csr_addr      = RAND_ADDR[$urandom_range(0, 15)];
            bus.csr_wdata     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            bus.csr_no_write  = (bus.csr_wdata == 0);
            bus.mret_req      = !bus.csr_en && ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        RST = 0;
        clr();
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
